// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtract-and-compare GCD engine with start/done handshake; optional GCD_ITER_COUNT_EN adds iter_cnt
module gcd_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_cnt
`endif
);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [WIDTH-1:0] r_gcd, w_gcd_nxt;
  logic             r_done;
  logic             w_accept;
  logic             w_finish;

  assign busy    = (r_state == S_CALC);
  assign done    = r_done;
  assign gcd_out = r_gcd;

  // Next-state and datapath decisions: one action per edge, zero/equal checks before subtraction
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_gcd_nxt   = r_gcd;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_a_nxt     = a_in;
          w_b_nxt     = b_in;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_a == '0) begin
          w_gcd_nxt = r_b;
          w_finish  = 1'b1;
        end else if (r_b == '0) begin
          w_gcd_nxt = r_a;
          w_finish  = 1'b1;
        end else if (r_a == r_b) begin
          w_gcd_nxt = r_a;
          w_finish  = 1'b1;
        end else if (r_a > r_b) begin
          w_a_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
        if (w_finish) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand, result and done-pulse registers; result only moves on a finish edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_gcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_a    <= w_a_nxt;
      r_b    <= w_b_nxt;
      r_gcd  <= w_gcd_nxt;
      r_done <= w_finish;
    end
  end

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_iter;

  assign iter_cnt = r_iter;

  // Subtraction counter: cleared on accept, bumped on every non-finishing CALC edge, published at finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_iter <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == S_CALC && !w_finish) begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
      if (w_finish) r_iter <= r_cnt;
    end
  end
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule
